// File: rtl/gpu_pkg.sv
// Shared encodings and default widths for the core scheduler and its per-core units.
package gpu_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;
    localparam int DEFAULT_ICACHE_LINES = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE     = 3'b000,
        FETCHER_FETCHING = 3'b001,
        FETCHER_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hit lookup, single fill port,
// synchronous active-low clear of the valid bits.
module icache_dm
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int LINES     = DEFAULT_ICACHE_LINES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_addr,
    output logic                 hit,
    output logic [DATA_BITS-1:0] hit_data,
    input  logic                 fill_en,
    input  logic [ADDR_BITS-1:0] fill_addr,
    input  logic [DATA_BITS-1:0] fill_data
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;
    localparam int TAG_W    = (TAG_BITS > 0) ? TAG_BITS : 1;

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [TAG_W-1:0]     tag_d  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];
    logic [DATA_BITS-1:0] data_d [LINES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]    lookup_tag;
    logic [TAG_W-1:0]    fill_tag;

    assign lookup_idx = lookup_addr[IDX_BITS-1:0];
    assign fill_idx   = fill_addr[IDX_BITS-1:0];

    // A cache as large as the address space has no tag bits; every valid line matches.
    generate
        if (TAG_BITS > 0) begin : g_tag
            assign lookup_tag = lookup_addr[ADDR_BITS-1:IDX_BITS];
            assign fill_tag   = fill_addr[ADDR_BITS-1:IDX_BITS];
        end else begin : g_no_tag
            assign lookup_tag = '0;
            assign fill_tag   = '0;
        end
    endgenerate

    always_comb begin
        hit      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        hit_data = data_q[lookup_idx];
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless while their valid bit is clear.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/instr_fetcher.sv
// Instruction fetch unit answering the scheduler's FETCH phase over a valid/ready memory read.
// Define INSTR_FETCHER_ICACHE_EN to build in the direct-mapped instruction cache.
module instr_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
    parameter int ICACHE_LINES          = DEFAULT_ICACHE_LINES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] ST_IDLE     = FETCHER_IDLE;
    localparam logic [2:0] ST_FETCHING = FETCHER_FETCHING;
    localparam logic [2:0] ST_FETCHED  = FETCHER_FETCHED;

    logic [2:0]                       state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;

    logic                             cache_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

`ifdef INSTR_FETCHER_ICACHE_EN
    logic cache_fill;

    // The line is filled from the latched request address, not the live PC.
    assign cache_fill = (state_q == ST_FETCHING) && mem_read_ready;

    icache_dm #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .LINES     (ICACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (current_pc),
        .hit         (cache_hit),
        .hit_data    (cache_data),
        .fill_en     (cache_fill),
        .fill_addr   (addr_q),
        .fill_data   (mem_read_data)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (cache_hit) begin
                        instr_d = cache_data;
                        state_d = ST_FETCHED;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                        state_d = ST_FETCHING;
                    end
                end
            end
            ST_FETCHING: begin
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    valid_d = 1'b0;
                    state_d = ST_FETCHED;
                end
            end
            ST_FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher against a program-memory / cache-contents reference model.
// Follows INSTR_FETCHER_ICACHE_EN to decide whether repeated PCs are expected to hit.
module tb_instr_fetcher;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int LINES = 16;

    localparam logic [2:0] CS_IDLE   = 3'b000;
    localparam logic [2:0] CS_FETCH  = 3'b001;
    localparam logic [2:0] CS_DECODE = 3'b010;

    localparam logic [2:0] FS_IDLE     = 3'b000;
    localparam logic [2:0] FS_FETCHING = 3'b001;
    localparam logic [2:0] FS_FETCHED  = 3'b010;

`ifdef INSTR_FETCHER_ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    core_state;
    logic [AW-1:0] current_pc;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic [2:0]    fetcher_state;
    logic [DW-1:0] instruction;

    // Reference model: program memory, which PC each cache line holds, last captured word.
    logic [DW-1:0] prog_mem [256];
    int            line_pc  [LINES];
    bit            line_ok  [LINES];
    logic [DW-1:0] exp_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetcher #(
        .PROGRAM_MEM_ADDR_BITS (AW),
        .PROGRAM_MEM_DATA_BITS (DW),
        .ICACHE_LINES          (LINES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit model_hit(input logic [AW-1:0] pc);
        int idx = int'(pc) % LINES;
        return CACHE_ON && line_ok[idx] && (line_pc[idx] == int'(pc));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) line_ok[i] = 1'b0;
        exp_instr = '0;
    endtask

    // One complete FETCH: request (or hit), memory wait, capture, hold in FETCHED, DECODE close-out.
    task automatic applyStimulus(input logic [AW-1:0] pc, input int waits, input int hold);
        bit hit = model_hit(pc);
        int idx = int'(pc) % LINES;
        core_state = CS_FETCH;
        current_pc = pc;
        tick();
        if (hit) begin
            exp_instr = prog_mem[pc];
            checkOutput("hit_state", 32'(fetcher_state), 32'(FS_FETCHED));
            checkOutput("hit_valid", 32'(mem_read_valid), 32'd0);
            checkOutput("hit_instr", 32'(instruction), 32'(exp_instr));
        end else begin
            for (int w = 0; w < waits; w++) begin
                checkOutput("wait_valid", 32'(mem_read_valid), 32'd1);
                checkOutput("wait_addr", 32'(mem_read_address), 32'(pc));
                checkOutput("wait_state", 32'(fetcher_state), 32'(FS_FETCHING));
                current_pc    = AW'($urandom);
                core_state    = 3'($urandom_range(0, 7));
                mem_read_data = DW'($urandom);
                tick();
            end
            checkOutput("req_valid", 32'(mem_read_valid), 32'd1);
            checkOutput("req_addr", 32'(mem_read_address), 32'(pc));
            core_state     = CS_FETCH;
            mem_read_ready = 1'b1;
            mem_read_data  = prog_mem[pc];
            tick();
            mem_read_ready = 1'b0;
            mem_read_data  = DW'($urandom);
            exp_instr      = prog_mem[pc];
            line_ok[idx]   = 1'b1;
            line_pc[idx]   = int'(pc);
            checkOutput("cap_state", 32'(fetcher_state), 32'(FS_FETCHED));
            checkOutput("cap_valid", 32'(mem_read_valid), 32'd0);
            checkOutput("cap_instr", 32'(instruction), 32'(exp_instr));
        end
        for (int h = 0; h < hold; h++) begin
            core_state     = CS_FETCH;
            mem_read_ready = 1'($urandom_range(0, 1));
            mem_read_data  = DW'($urandom);
            tick();
            checkOutput("hold_state", 32'(fetcher_state), 32'(FS_FETCHED));
            checkOutput("hold_valid", 32'(mem_read_valid), 32'd0);
            checkOutput("hold_instr", 32'(instruction), 32'(exp_instr));
        end
        mem_read_ready = 1'b0;
        core_state     = CS_DECODE;
        tick();
        checkOutput("close_state", 32'(fetcher_state), 32'(FS_IDLE));
        checkOutput("close_valid", 32'(mem_read_valid), 32'd0);
        checkOutput("close_instr", 32'(instruction), 32'(exp_instr));
        core_state = CS_IDLE;
    endtask

    task automatic stray_ready(input logic [DW-1:0] data);
        core_state     = CS_IDLE;
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        checkOutput("stray_instr", 32'(instruction), 32'(exp_instr));
        checkOutput("stray_state", 32'(fetcher_state), 32'(FS_IDLE));
        checkOutput("stray_valid", 32'(mem_read_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog_mem[i] = DW'($urandom);
        prog_mem[8'h05] = 16'hA1B2;
        prog_mem[8'h10] = 16'h1234;
        model_clear();

        reset          = 1'b0;
        core_state     = CS_IDLE;
        current_pc     = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        tick();
        tick();
        checkOutput("rst_state", 32'(fetcher_state), 32'(FS_IDLE));
        checkOutput("rst_valid", 32'(mem_read_valid), 32'd0);
        checkOutput("rst_addr", 32'(mem_read_address), 32'd0);
        checkOutput("rst_instr", 32'(instruction), 32'd0);
        reset = 1'b1;
        tick();

        stray_ready(16'hFFFF);

        $display("[TB] basic miss and close-out");
        applyStimulus(8'h05, 3, 4);

        $display("[TB] repeated PC");
        applyStimulus(8'h10, 1, 0);
        applyStimulus(8'h10, 2, 1);

        $display("[TB] conflicting PCs");
        applyStimulus(8'h03, 0, 0);
        applyStimulus(8'h13, 1, 0);
        applyStimulus(8'h03, 2, 0);

        $display("[TB] reset mid-request");
        core_state = CS_FETCH;
        current_pc = 8'h21;
        tick();
        checkOutput("mid_state", 32'(fetcher_state), 32'(FS_FETCHING));
        checkOutput("mid_valid", 32'(mem_read_valid), 32'd1);
        core_state = CS_IDLE;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_clear();
        checkOutput("mrst_valid", 32'(mem_read_valid), 32'd0);
        checkOutput("mrst_state", 32'(fetcher_state), 32'(FS_IDLE));
        checkOutput("mrst_instr", 32'(instruction), 32'd0);
        checkOutput("mrst_addr", 32'(mem_read_address), 32'd0);
        tick();
        stray_ready(prog_mem[8'h21]);
        applyStimulus(8'h10, 0, 0);

        $display("[TB] randomized fetches");
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] pc;
            pc = AW'($urandom_range(0, 5)) | AW'($urandom_range(0, 2) << 4);
            if ($urandom_range(0, 3) == 0) stray_ready(DW'($urandom));
            applyStimulus(pc, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetcher.md
# instr_fetcher

Per-core instruction fetch unit: the responder to the core scheduler's FETCH phase. It samples the scheduler's `core_state` and `current_pc`, reads the instruction word from program memory over a valid/ready handshake, and reports progress on `fetcher_state`. The scheduler advances to DECODE when `fetcher_state` reads FETCHED. An optional direct-mapped instruction cache removes memory round-trips for repeated PCs, for example loop bodies.

## Interface
- `PROGRAM_MEM_ADDR_BITS`, 8: PC and program-memory address width.
- `PROGRAM_MEM_DATA_BITS`, 16: instruction word width.
- `ICACHE_LINES`, 16: cache lines. Must be a power of two, at least 2, and no more than 2^ADDR_BITS. Used only when the cache is compiled in.

Ports:
- `clk`  in  1  core clock. One clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `core_state`  in  3  scheduler state. FETCH=3'b001, DECODE=3'b010.
- `current_pc`  in  ADDR_BITS  PC of the instruction to fetch.
- `mem_read_valid`  out  1  program-memory read request.
- `mem_read_address`  out  ADDR_BITS  request address.
- `mem_read_ready`  in  1  memory response strobe; data is valid in the same cycle.
- `mem_read_data`  in  DATA_BITS  instruction word.
- `fetcher_state`  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
- `instruction`  out  DATA_BITS  fetched instruction word. Held stable until the next capture.

## Operation
- **Reset values** (`reset`==0 at a rising edge):
  - `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0.
  - All cache valid bits cleared.
- **IDLE**: when `core_state`==FETCH:
  - Cache hit: load `instruction` from the cache, go to FETCHED. No memory request.
  - Otherwise: `mem_read_valid`<=1, `mem_read_address`<=`current_pc`, go to FETCHING.
  - Any other `core_state`: stay in IDLE.
- **FETCHING**:
  - Valid and address are held stable until `mem_read_ready`==1 is sampled.
  - On that edge: `instruction`<=`mem_read_data`, `mem_read_valid`<=0, fill the cache line, go to FETCHED.
  - Changes to `current_pc` or `core_state` during FETCHING are ignored.
- **FETCHED**: when `core_state`==DECODE, go to IDLE. Otherwise hold.
- `mem_read_ready` while `mem_read_valid`==0 is ignored. There are no spurious captures.
- The fetcher never issues a second request before the first completes. At most one request is outstanding.
- **Reset mid-request**: `mem_read_valid` drops at that edge. A `mem_read_ready` arriving afterward is ignored.
- **Cache organisation**:
  - Direct-mapped. Index = `current_pc[log2(ICACHE_LINES)-1:0]`. Tag = the remaining upper PC bits. One valid bit per line.
  - Fills overwrite unconditionally.
  - Program memory is read-only during a kernel, so there is no other invalidation path.

## Timing
- Cycle 0 is the edge at which `core_state`==FETCH is first sampled in IDLE.
- **Miss**:
  - `mem_read_valid` is high from cycle 0+.
  - The earliest `mem_read_ready` sample is edge 1.
  - `fetcher_state`==FETCHED and `instruction` are valid after edge 1 + memory wait cycles.
  - Minimum total: 2 edges.
- **Hit**: `fetcher_state`==FETCHED after edge 0. Single-cycle.
- FETCHED→IDLE happens at the first edge where `core_state`==DECODE. The scheduler enters DECODE one edge after observing FETCHED.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `INSTR_FETCHER_ICACHE_EN` defined:
  - Cache, lookup and fill logic are instantiated.
  - Hits complete in 1 cycle with `mem_read_valid` never asserted.
- Not defined:
  - No cache storage. Every FETCH takes the miss path.
  - `ICACHE_LINES` is unused.
  - Port list is identical in both builds.

## Structure
- **Shared package `gpu_pkg`**:
  - `core_state_t` encodings: IDLE..DONE, 3'b000–3'b111.
  - `fetcher_state_t` encodings: IDLE/FETCHING/FETCHED.
  - Default address/data width constants.
- **Sub-module `icache_dm`**:
  - Tag/valid/data arrays and combinational hit lookup.
  - Write port for fill.
  - Synchronous active-low clear.
  - Instantiated only under `INSTR_FETCHER_ICACHE_EN`.

## Test plan
- **Basic miss**: reset, PC=8'h05, core_state=FETCH, memory ready after 3 cycles with 16'hA1B2.
  - Expect valid high with address 8'h05 until ready.
  - Then FETCHED, `instruction`=16'hA1B2, valid low.
- **Handshake close-out**: in FETCHED, hold core_state=FETCH for 4 cycles, then DECODE.
  - Expect FETCHED to be held, then IDLE one edge after DECODE.
  - Expect no new request.
- **Cache hit** (EN build): fetch PC 8'h10 (miss, 16'h1234), then fetch 8'h10 again.
  - Second fetch: FETCHED after 1 edge, `mem_read_valid` stays 0, `instruction`=16'h1234.
- **Conflict eviction** (EN build, 16 lines): fetch 8'h03, then 8'h13, then 8'h03.
  - Expect all three to issue memory requests.
  - Expect the correct data each time.
- **Reset mid-request**: assert reset during FETCHING, then pulse ready one cycle after reset releases.
  - Expect valid=0, state IDLE, `instruction`=0, no capture.
  - EN build: the next fetch of the same PC misses.
- **Stray ready**: pulse `mem_read_ready` with 16'hFFFF while IDLE.
  - Expect `instruction` unchanged and state IDLE.
